// File: rtl/interp_pkg.sv
// Shared definitions for the interpolation RAM reader.
// Contents:
//   - default width constants for address, sample and fraction fields
//   - PHASE_WIDTH: width of the phase accumulator
//     (address bits + 1 guard bit + fraction bits)
//   - state_t: read/interpolate FSM states
package interp_pkg;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FRAC_WIDTH = 8;
  localparam int PHASE_WIDTH    = DEF_ADDR_WIDTH + 1 + DEF_FRAC_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR0 = 3'd1,
    ST_ADDR1 = 3'd2,
    ST_CAP   = 3'd3,
    ST_MUL   = 3'd4,
    ST_OUT   = 3'd5,
    ST_FIN   = 3'd6
  } state_t;

endpackage

// File: rtl/interp_lerp.sv
// Linear interpolation datapath.
// It captures the two neighbouring samples s0 and s1 and registers
// s0 + (((s1 - s0) * frac) >>> FRAC_WIDTH).
// The arithmetic is kept in its own module so that a DSP-mapped
// multiplier can be substituted without touching the controller.
// Ports:
//   clk, rst  clock; asynchronous active-high reset
//   rd_data   RAM read data (sample)
//   frac      fractional phase bits
//   load_s0   capture rd_data into s0
//   load_s1   capture rd_data into s1
//   calc      register the interpolated result
//   result    registered interpolated sample
module interp_lerp #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic [FRAC_WIDTH-1:0] frac,
  input  logic                  load_s0,
  input  logic                  load_s1,
  input  logic                  calc,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int PRODW = DATA_WIDTH + FRAC_WIDTH + 2;

  logic [DATA_WIDTH-1:0] s0_r;
  logic [DATA_WIDTH-1:0] s1_r;
  logic [DATA_WIDTH-1:0] result_r;
  logic [DATA_WIDTH:0]   diff_s;
  logic [PRODW-1:0]      diff_ext_s;
  logic [PRODW-1:0]      frac_ext_s;
  logic [PRODW-1:0]      prod_s;
  logic [DATA_WIDTH-1:0] shift_s;
  logic [DATA_WIDTH-1:0] lerp_s;
  logic                  unused_prod_s;

  // Interpolation arithmetic.
  // The modular product of the operands, once they are sign/zero-extended
  // to PRODW, equals the exact signed product, because that product always
  // fits. Taking bits [FRAC+DATA-1:FRAC] equals an arithmetic right shift
  // truncated to DATA_WIDTH. That truncation is exact, because the
  // interpolated value lies between s0 and s1.
  always_comb begin
    diff_s     = {s1_r[DATA_WIDTH-1], s1_r} - {s0_r[DATA_WIDTH-1], s0_r};
    diff_ext_s = {{(FRAC_WIDTH+1){diff_s[DATA_WIDTH]}}, diff_s};
    frac_ext_s = {{(DATA_WIDTH+2){1'b0}}, frac};
    prod_s     = diff_ext_s * frac_ext_s;
    shift_s    = prod_s[DATA_WIDTH+FRAC_WIDTH-1:FRAC_WIDTH];
    lerp_s     = s0_r + shift_s;
  end

  assign unused_prod_s = ^{prod_s[PRODW-1:DATA_WIDTH+FRAC_WIDTH], prod_s[FRAC_WIDTH-1:0]};

  // Sample capture and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_r     <= {DATA_WIDTH{1'b0}};
      s1_r     <= {DATA_WIDTH{1'b0}};
      result_r <= {DATA_WIDTH{1'b0}};
    end else begin
      if (load_s0) s0_r <= rd_data;
      if (load_s1) s1_r <= rd_data;
      if (calc)    result_r <= lerp_s;
    end
  end

  assign result = result_r;

endmodule

// File: rtl/interp_ram_reader.sv
// Read-side controller for the interpolation sample RAM.
// The RAM has a one-cycle read latency.
// After a start pulse, a fractional phase accumulator walks over the
// stored samples. For each phase, the controller fetches the adjacent
// sample pair and emits one linearly interpolated result on a
// valid/ready stream.
// Build option:
//   INTERP_SKIP_REFETCH_EN  When the phase advance leaves the integer
//                           index unchanged, the controller reuses the
//                           captured sample pair and skips the RAM reads.
// Ports:
//   rd_clk, rd_rst  clock; asynchronous active-high reset
//   start           run request (accepted in IDLE only)
//   len, step       sample count and Q.FRAC phase increment, sampled on start
//   rd_addr         RAM read address
//   rd_data         RAM read data (one cycle after rd_addr)
//   m_data, m_valid, m_ready   output stream
//   busy            high whenever the FSM is not idle
//   done            one-cycle pulse at the end of a run
module interp_ram_reader
  import interp_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_WIDTH = DEF_FRAC_WIDTH
) (
  input  logic                             rd_clk,
  input  logic                             rd_rst,
  input  logic                             start,
  input  logic [ADDR_WIDTH:0]              len,
  input  logic [ADDR_WIDTH+FRAC_WIDTH-1:0] step,
  output logic [ADDR_WIDTH-1:0]            rd_addr,
  input  logic [DATA_WIDTH-1:0]            rd_data,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic                             busy,
  output logic                             done
);

  localparam int PW = ADDR_WIDTH + 1 + FRAC_WIDTH;
  localparam int IW = ADDR_WIDTH + 1;

`ifdef INTERP_SKIP_REFETCH_EN
  localparam logic SKIP_REFETCH = 1'b1;
`else
  localparam logic SKIP_REFETCH = 1'b0;
`endif

  state_t                         state_r, state_nx_s;
  logic [PW-1:0]                  phase_r, phase_nx_s, phase_add_s;
  logic [IW-1:0]                  len_r, len_nx_s;
  logic [ADDR_WIDTH+FRAC_WIDTH-1:0] step_r, step_nx_s;
  logic [ADDR_WIDTH-1:0]          rd_addr_r, rd_addr_nx_s;
  logic                           m_valid_r, busy_r, done_r;
  logic [IW-1:0]                  i_cur_s, i_add_s, i_inc_s, last_idx_s, next_addr_s;
  logic                           load_s0_s, load_s1_s, calc_s;
  logic                           unused_addr_s;

  // Integer parts of the current and advanced phase, and the clamped s1 address.
  always_comb begin
    i_cur_s     = phase_r[PW-1:FRAC_WIDTH];
    phase_add_s = phase_r + {1'b0, step_r};
    i_add_s     = phase_add_s[PW-1:FRAC_WIDTH];
    i_inc_s     = i_cur_s + {{(IW-1){1'b0}}, 1'b1};
    last_idx_s  = len_r - {{(IW-1){1'b0}}, 1'b1};
    if (i_inc_s > last_idx_s) begin
      next_addr_s = last_idx_s;
    end else begin
      next_addr_s = i_inc_s;
    end
  end

  assign unused_addr_s = next_addr_s[ADDR_WIDTH];

  // FSM state register.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) state_r <= ST_IDLE;
    else        state_r <= state_nx_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if ((len == {IW{1'b0}}) || (step == {(ADDR_WIDTH+FRAC_WIDTH){1'b0}})) begin
            state_nx_s = ST_FIN;
          end else begin
            state_nx_s = ST_ADDR0;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ADDR0: state_nx_s = ST_ADDR1;
      ST_ADDR1: state_nx_s = ST_CAP;
      ST_CAP:   state_nx_s = ST_MUL;
      ST_MUL:   state_nx_s = ST_OUT;
      ST_OUT: begin
        if (m_ready) begin
          if (i_add_s >= len_r) begin
            state_nx_s = ST_FIN;
          end else if (SKIP_REFETCH && (i_add_s == i_cur_s)) begin
            state_nx_s = ST_MUL;
          end else begin
            state_nx_s = ST_ADDR0;
          end
        end else begin
          state_nx_s = ST_OUT;
        end
      end
      ST_FIN:   state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Output logic and datapath next values. The read address is loaded
  // on entry to ADDR0/ADDR1, so it is valid throughout those states.
  always_comb begin
    phase_nx_s   = phase_r;
    len_nx_s     = len_r;
    step_nx_s    = step_r;
    rd_addr_nx_s = rd_addr_r;
    load_s0_s    = 1'b0;
    load_s1_s    = 1'b0;
    calc_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (state_nx_s == ST_ADDR0) begin
          phase_nx_s   = {PW{1'b0}};
          len_nx_s     = len;
          step_nx_s    = step;
          rd_addr_nx_s = {ADDR_WIDTH{1'b0}};
        end else begin
          phase_nx_s   = phase_r;
        end
      end
      ST_ADDR0: rd_addr_nx_s = next_addr_s[ADDR_WIDTH-1:0];
      ST_ADDR1: load_s0_s = 1'b1;
      ST_CAP:   load_s1_s = 1'b1;
      ST_MUL:   calc_s    = 1'b1;
      ST_OUT: begin
        if (m_ready) begin
          phase_nx_s = phase_add_s;
          if (state_nx_s == ST_ADDR0) begin
            rd_addr_nx_s = i_add_s[ADDR_WIDTH-1:0];
          end else begin
            rd_addr_nx_s = rd_addr_r;
          end
        end else begin
          phase_nx_s = phase_r;
        end
      end
      ST_FIN:   phase_nx_s = phase_r;
      default:  phase_nx_s = phase_r;
    endcase
  end

  // Datapath and registered status outputs.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      phase_r   <= {PW{1'b0}};
      len_r     <= {IW{1'b0}};
      step_r    <= {(ADDR_WIDTH+FRAC_WIDTH){1'b0}};
      rd_addr_r <= {ADDR_WIDTH{1'b0}};
      m_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      phase_r   <= phase_nx_s;
      len_r     <= len_nx_s;
      step_r    <= step_nx_s;
      rd_addr_r <= rd_addr_nx_s;
      m_valid_r <= (state_nx_s == ST_OUT);
      busy_r    <= (state_nx_s != ST_IDLE);
      done_r    <= (state_nx_s == ST_FIN);
    end
  end

  interp_lerp #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_lerp (
    .clk     (rd_clk),
    .rst     (rd_rst),
    .rd_data (rd_data),
    .frac    (phase_r[FRAC_WIDTH-1:0]),
    .load_s0 (load_s0_s),
    .load_s1 (load_s1_s),
    .calc    (calc_s),
    .result  (m_data)
  );

  assign rd_addr = rd_addr_r;
  assign m_valid = m_valid_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_interp_ram_reader.sv
// Self-checking bench for interp_ram_reader.
// A behavioural RAM model with one-cycle read latency feeds the DUT.
// Expected outputs come from a plain-arithmetic model of the phase walk.
module tb_interp_ram_reader;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int FW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   len;
  logic [AW+FW-1:0] step;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [1024];
  longint        exp_q [$];
  int            checks = 0;
  int            errors = 0;
  int            r_addr1, r_addr2, r_valid1, r_valid2, r_done_cyc, r_nout, r_done_cnt, r_nrise;

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  interp_ram_reader dut (
    .rd_clk  (clk),
    .rd_rst  (rst),
    .start   (start),
    .len     (len),
    .step    (step),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .busy    (busy),
    .done    (done)
  );

  task automatic chk(input string tag, input longint got, input longint expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: every phase value with integer part below len yields
  // s0 + floor((s1 - s0) * f / 2^FW), where s1 is clamped to the last sample.
  task automatic build_exp(input int ln, input int st);
    longint ph, i, f, i1, s0, s1;
    exp_q.delete();
    if (ln > 0 && st > 0) begin
      ph = 0;
      while ((ph >> FW) < ln) begin
        i  = ph >> FW;
        f  = ph & 255;
        i1 = (i + 1 < ln) ? i + 1 : ln - 1;
        s0 = longint'($signed(mem[int'(i)]));
        s1 = longint'($signed(mem[int'(i1)]));
        exp_q.push_back(s0 + (((s1 - s0) * f) >>> FW));
        ph += st;
      end
    end
  endtask

  // mode 0: ready held high; 1: random ready; 2: ten stall cycles on the first output
  task automatic run(input string nm, input int ln, input int st, input int mode, input bit extra);
    int cyc, stall_left;
    bit prev_valid, prev_stall, finished;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_addr;
    build_exp(ln, st);
    start   = 1'b1;
    len     = ln[AW:0];
    step    = st[AW+FW-1:0];
    m_ready = (mode != 2);
    tick();
    start = 1'b0;
    len   = 11'($urandom);
    step  = 18'($urandom);
    cyc = 1; stall_left = 10; finished = 1'b0;
    prev_valid = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_addr = '0;
    r_nout = 0; r_done_cnt = 0; r_nrise = 0; r_valid1 = 0; r_valid2 = 0; r_done_cyc = 0;
    while (!finished && cyc < 20000) begin
      if (cyc == 1) begin
        r_addr1 = int'(rd_addr);
        chk({nm, " busy_c1"}, busy, 1);
      end
      if (cyc == 2) r_addr2 = int'(rd_addr);
      if (m_valid && !prev_valid) begin
        r_nrise++;
        if (r_nrise == 1) r_valid1 = cyc;
        if (r_nrise == 2) r_valid2 = cyc;
      end
      if (prev_stall) begin
        chk({nm, " hold_valid"}, m_valid, 1);
        chk({nm, " hold_data"}, m_data, prev_data);
        chk({nm, " hold_addr"}, rd_addr, prev_addr);
      end
      if (r_done_cnt > 0) begin
        chk({nm, " busy_after_done"}, busy, 0);
        chk({nm, " done_one_cycle"}, done, 0);
        chk({nm, " valid_after_done"}, m_valid, 0);
        finished = 1'b1;
      end else begin
        if (done) begin
          r_done_cnt++;
          r_done_cyc = cyc;
        end
        case (mode)
          0: m_ready = 1'b1;
          1: m_ready = ($urandom_range(0, 3) != 0);
          2: begin
            if (m_valid && stall_left > 0) begin
              m_ready = 1'b0;
              stall_left--;
            end else begin
              m_ready = 1'b1;
            end
          end
          default: m_ready = 1'b1;
        endcase
        if (m_valid && m_ready) begin
          if (r_nout < exp_q.size())
            chk({nm, " data"}, longint'($signed(m_data)), exp_q[r_nout]);
          else
            chk({nm, " extra_output"}, r_nout, exp_q.size());
          r_nout++;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_addr  = rd_addr;
      end
      prev_valid = m_valid;
      start = extra && (cyc == 3);
      if (start) begin
        len  = 11'd5;
        step = 18'd1;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    chk({nm, " finished"}, finished, 1);
    chk({nm, " out_count"}, r_nout, exp_q.size());
    chk({nm, " done_count"}, r_done_cnt, 1);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 1024; i++) mem[i] = DW'(i * 256);
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1; start = 1'b0; len = '0; step = '0; m_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rd_addr", rd_addr, 0);
    chk("reset m_data", m_data, 0);
    chk("reset m_valid", m_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    rst = 1'b0;
    tick();

    fill_ramp();
    run("ramp", 4, 32'h080, 0, 1'b0);
    chk("ramp rd_addr_c1", r_addr1, 0);
    chk("ramp rd_addr_c2", r_addr2, 1);
    chk("ramp first_valid", r_valid1, 5);
`ifdef INTERP_SKIP_REFETCH_EN
    chk("ramp second_valid", r_valid2, 7);
`else
    chk("ramp second_valid", r_valid2, 10);
`endif

    mem[0] = 32'd100;
    mem[1] = 32'hFFFF_FF9C;
    run("neg", 2, 32'h040, 0, 1'b0);

    fill_ramp();
    run("backpressure", 4, 32'h080, 2, 1'b0);

    run("len0", 0, 32'h080, 0, 1'b0);
    chk("len0 done_cycle", r_done_cyc, 1);
    chk("len0 no_valid", r_nrise, 0);

    run("step0", 4, 0, 0, 1'b0);
    chk("step0 done_cycle", r_done_cyc, 1);
    chk("step0 no_valid", r_nrise, 0);

    mem[0] = $urandom;
    run("len1", 1, 32'h100, 0, 1'b0);

    fill_ramp();
    run("busy_start", 4, 32'h080, 0, 1'b1);

    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    run("len1024_a", 1024, 32'h4000, 1, 1'b0);
    run("len1024_b", 1024, 32'h3FF00, 1, 1'b0);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      run("random", $urandom_range(1, 24), $urandom_range(1, 32'h300), 1, 1'b0);
    end

    // Reset while the FSM is in CAP (cycle 3 after the start edge).
    fill_ramp();
    start = 1'b1; len = 11'd4; step = 18'h080; m_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst busy", busy, 0);
    tick();
    chk("midrst rd_addr", rd_addr, 0);
    chk("midrst m_data", m_data, 0);
    chk("midrst m_valid", m_valid, 0);
    chk("midrst done", done, 0);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done || m_valid) saw_done = 1'b1;
    end
    chk("midrst no_done_or_valid", saw_done, 0);
    chk("midrst idle", busy, 0);
    run("after_reset", 4, 32'h080, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
